regfile_wb_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the 32x32 register bank (single write port, x0 hardwired to zero). It shares the one write port between two requesters:
- the in-order ALU writeback path (port A), which cannot normally stall;
- the long-latency unit writeback (port B: loads/mul/div), which uses a valid/ready handshake.
It also tracks registers with an outstanding long-latency result so hazard logic can stall dependent instructions. It sits between the execute/writeback stages and the register bank's RegWrite/writeReg/writeData inputs.

---
 rtl/regfile_wb_arbiter.sv | 143 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter and pending-result scoreboard for the 32x32 register bank.
// Port A (in-order ALU writeback) normally wins the single write port. Port B
// (long-latency loads/mul/div) takes it whenever A is idle. After STARVE_LIMIT
// consecutive refusals, B is forced through and A is stalled for one cycle.
// The scoreboard marks destinations of issued long-latency ops as busy until
// their port-B writeback is accepted.

module regfile_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            CLK,
  input  logic            RST,

  // Port A: ALU writeback (cannot stall except when B is forced through)
  input  logic            a_valid,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  output logic            a_stall,

  // Port B: long-latency writeback, valid/ready handshake
  input  logic            b_valid,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,

  // Long-latency issue, checked against the scoreboard
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  output logic            iss_ready,
  output logic [31:0]     busy,

  // Register bank write port
  output logic            RegWrite,
  output logic [4:0]      writeReg,
  output logic [XLEN-1:0] writeData
);

  localparam int            CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  // State
  logic [31:0]   busy_q,  busy_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          force_q, force_d;

  // Arbitration intermediates
  logic a_req;
  logic b_req;
  logic force_b;
  logic grant_a;
  logic grant_b;

  // Decide who owns the write port this cycle; everything is quiet in reset.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the logic can leave it unassigned and infer a latch.
    a_req   = a_valid && (a_rd != 5'd0);
    b_req   = b_valid;
    force_b = force_q && b_req;
    grant_a = 1'b0;
    grant_b = 1'b0;
    a_stall = 1'b0;

    if (!RST) begin
      if (force_b) begin
        grant_b = 1'b1;
        a_stall = a_req;
      end else if (a_req) begin
        grant_a = 1'b1;
      end else if (b_req) begin
        grant_b = 1'b1;
      end
    end

    b_ready = grant_b;
  end

  // Steer the winner onto the bank; a port-B write to x0 is handshaked only.
  always_comb begin
    RegWrite  = 1'b0;
    writeReg  = 5'd0;
    writeData = '0;
    if (grant_a) begin
      RegWrite  = 1'b1;
      writeReg  = a_rd;
      writeData = a_data;
    end else if (grant_b) begin
      RegWrite  = (b_rd != 5'd0);
      writeReg  = b_rd;
      writeData = b_data;
    end
  end

  // Count consecutive refusals of port B and raise the force flag at the limit.
  always_comb begin
    cnt_d   = cnt_q;
    force_d = force_q;
    if (grant_b) begin
      cnt_d   = '0;
      force_d = 1'b0;
    end else if (force_q && !b_valid) begin
      // B withdrew while being forced: drop the force, nobody is stalled.
      cnt_d   = '0;
      force_d = 1'b0;
    end else if (b_req) begin
      cnt_d = (cnt_q >= LIMIT_C) ? LIMIT_C : cnt_q + CW'(1);
      if (cnt_d == LIMIT_C) force_d = 1'b1;
    end
  end

  // Issue handshake: a register with a pending result cannot be re-targeted.
  always_comb begin
    iss_ready = !RST && ((iss_rd == 5'd0) || !busy_q[iss_rd]);
  end

  // Scoreboard update: clear on accepted B writeback, set on accepted issue.
  always_comb begin
    busy_d = busy_q;
    if (grant_b) busy_d[b_rd] = 1'b0;
    if (iss_valid && iss_ready && (iss_rd != 5'd0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign busy = {busy_q[31:1], 1'b0};

  // State registers.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order. The scoreboard is
    // only 32 flops (not a RAM), so it is reset along with the rest.
    if (RST) begin
      busy_q  <= '0;
      cnt_q   <= '0;
      force_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      force_q <= force_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter. Each cycle the expected
// write-port result is pushed to a scoreboard queue when stimulus is driven
// and popped/compared while the DUT output is settled (on the negedge).
// Inputs change 1 time unit after posedge.

module tb_regfile_wb_arbiter;

  localparam int XLEN         = 32;
  localparam int STARVE_LIMIT = 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic            a_valid;
  logic [4:0]      a_rd;
  logic [XLEN-1:0] a_data;
  logic            a_stall;
  logic            b_valid;
  logic [4:0]      b_rd;
  logic [XLEN-1:0] b_data;
  logic            b_ready;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic            iss_ready;
  logic [31:0]     busy;
  logic            RegWrite;
  logic [4:0]      writeReg;
  logic [XLEN-1:0] writeData;

  int checks = 0;
  int errors = 0;

  // Expected scoreboard contents, maintained by the tests themselves.
  logic [31:0] exp_busy;

  typedef struct {
    string           name;
    logic            rw;
    logic [4:0]      wr;
    logic [XLEN-1:0] wd;
    logic            br;
    logic            st;
  } exp_t;

  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  regfile_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .a_valid   (a_valid),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .a_stall   (a_stall),
    .b_valid   (b_valid),
    .b_rd      (b_rd),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .busy      (busy),
    .RegWrite  (RegWrite),
    .writeReg  (writeReg),
    .writeData (writeData)
  );

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid   = 1'b0; a_rd = 5'd0; a_data = '0;
    b_valid   = 1'b0; b_rd = 5'd0; b_data = '0;
    iss_valid = 1'b0; iss_rd = 5'd0;
  endtask

  task automatic push_exp(input string name, input logic rw, input logic [4:0] wr,
                          input logic [XLEN-1:0] wd, input logic br, input logic st);
    exp_t e;
    e.name = name; e.rw = rw; e.wr = wr; e.wd = wd; e.br = br; e.st = st;
    exp_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare it against the settled write port.
  task automatic sb_pop_compare();
    exp_t e;
    @(negedge CLK);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: DUT output with no expectation queued");
      return;
    end
    e = exp_q.pop_front();
    if ({RegWrite, writeReg, writeData, b_ready, a_stall} !== {e.rw, e.wr, e.wd, e.br, e.st}) begin
      errors++;
      $display("FAIL %s: got rw=%0b wr=%0d wd=%h b_ready=%0b a_stall=%0b, expected rw=%0b wr=%0d wd=%h b_ready=%0b a_stall=%0b",
               e.name, RegWrite, writeReg, writeData, b_ready, a_stall,
               e.rw, e.wr, e.wd, e.br, e.st);
    end
  endtask

  task automatic check_busy(input string name);
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL %s: busy=%h expected %h", name, busy, exp_busy);
    end
  endtask

  // A held on a_rd, B held on b_rd: four refusals, then B forced with A stalled.
  task automatic contention(input string name, input logic [4:0] ard, input logic [XLEN-1:0] adat,
                            input logic [4:0] brd, input logic [XLEN-1:0] bdat);
    a_valid = 1'b1; a_rd = ard; a_data = adat;
    b_valid = 1'b1; b_rd = brd; b_data = bdat;
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      push_exp($sformatf("%s_refuse%0d", name, i), 1'b1, ard, adat, 1'b0, 1'b0);
      sb_pop_compare();
      next_cycle();
    end
    push_exp($sformatf("%s_forced", name), (brd != 5'd0), brd, bdat, 1'b1, 1'b1);
    sb_pop_compare();
    next_cycle();
    b_valid = 1'b0;
    exp_busy[brd] = 1'b0;
    exp_busy[0]   = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h1;
    b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h2;
    iss_valid = 1'b1; iss_rd = 5'd6;
    exp_busy = '0;
    push_exp("reset_outputs", 1'b0, 5'd0, '0, 1'b0, 1'b0);
    sb_pop_compare();
    checks++;
    if (iss_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_iss_ready: got %0b expected 0", iss_ready);
    end
    check_busy("reset_busy");
    next_cycle();
    idle_inputs();
    RST = 1'b0;
    next_cycle();
  endtask

  task automatic test_a_only();
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hDEADBEEF;
    push_exp("a_only", 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0);
    sb_pop_compare();
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_starvation();
    contention("starve", 5'd7, 32'hA7, 5'd9, 32'h11);
    // Cycle 5: A wins again.
    push_exp("starve_after_force", 1'b1, 5'd7, 32'hA7, 1'b0, 1'b0);
    sb_pop_compare();
    next_cycle();
    // Counter restarted from 0: a new B request needs four more refusals.
    contention("starve_again", 5'd7, 32'hA8, 5'd10, 32'h22);
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_scoreboard();
    iss_valid = 1'b1; iss_rd = 5'd12;
    @(negedge CLK);
    checks++;
    if (iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL sb_first_issue_ready: got %0b expected 1", iss_ready);
    end
    next_cycle();
    exp_busy[12] = 1'b1;
    check_busy("sb_busy_set");
    @(negedge CLK);
    checks++;
    if (iss_ready !== 1'b0) begin
      errors++;
      $display("FAIL sb_reissue_blocked: got %0b expected 0", iss_ready);
    end
    next_cycle();
    // B writeback of r12 while the re-issue is still being attempted.
    b_valid = 1'b1; b_rd = 5'd12; b_data = 32'h1234;
    push_exp("sb_b_write", 1'b1, 5'd12, 32'h1234, 1'b1, 1'b0);
    sb_pop_compare();
    checks++;
    if (iss_ready !== 1'b0) begin
      errors++;
      $display("FAIL sb_same_cycle_issue: got %0b expected 0", iss_ready);
    end
    next_cycle();
    b_valid = 1'b0;
    exp_busy[12] = 1'b0;
    check_busy("sb_busy_cleared");
    @(negedge CLK);
    checks++;
    if (iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL sb_reissue_after_clear: got %0b expected 1", iss_ready);
    end
    next_cycle();
    exp_busy[12] = 1'b1;
    check_busy("sb_busy_reset_again");
    // Issue r13 and retire r12 in the same cycle: both take effect.
    iss_rd = 5'd13;
    b_valid = 1'b1; b_rd = 5'd12; b_data = 32'h5678;
    push_exp("sb_concurrent_b", 1'b1, 5'd12, 32'h5678, 1'b1, 1'b0);
    sb_pop_compare();
    next_cycle();
    idle_inputs();
    exp_busy[12] = 1'b0;
    exp_busy[13] = 1'b1;
    check_busy("sb_concurrent_update");
    // Port A may write a busy register without touching the scoreboard.
    a_valid = 1'b1; a_rd = 5'd13; a_data = 32'hCAFE;
    push_exp("sb_a_writes_busy", 1'b1, 5'd13, 32'hCAFE, 1'b0, 1'b0);
    sb_pop_compare();
    next_cycle();
    idle_inputs();
    check_busy("sb_a_no_effect");
  endtask

  task automatic test_x0();
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF;
    b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h44;
    push_exp("x0_a_nop_b_wins", 1'b1, 5'd4, 32'h44, 1'b1, 1'b0);
    sb_pop_compare();
    next_cycle();
    idle_inputs();
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h99;
    push_exp("x0_b_handshake_only", 1'b0, 5'd0, 32'h99, 1'b1, 1'b0);
    sb_pop_compare();
    next_cycle();
    idle_inputs();
    iss_valid = 1'b1; iss_rd = 5'd0;
    @(negedge CLK);
    checks++;
    if (iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_issue_ready: got %0b expected 1", iss_ready);
    end
    next_cycle();
    idle_inputs();
    check_busy("x0_busy_unchanged");
  endtask

  task automatic test_idle_a();
    b_valid = 1'b1; b_rd = 5'd20; b_data = 32'h55;
    push_exp("idle_a_b_immediate", 1'b1, 5'd20, 32'h55, 1'b1, 1'b0);
    sb_pop_compare();
    next_cycle();
    idle_inputs();
    // Counter stayed at 0: contention again takes the full four refusals.
    contention("idle_a_then_contend", 5'd2, 32'h202, 5'd21, 32'h66);
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_force_drop();
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h77;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h99;
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      push_exp($sformatf("drop_refuse%0d", i), 1'b1, 5'd7, 32'h77, 1'b0, 1'b0);
      sb_pop_compare();
      next_cycle();
    end
    // Force is set, but B withdraws: A must not stall.
    b_valid = 1'b0;
    push_exp("drop_no_stall", 1'b1, 5'd7, 32'h77, 1'b0, 1'b0);
    sb_pop_compare();
    next_cycle();
    // Force and counter cleared: B again needs four refusals.
    contention("drop_recount", 5'd7, 32'h78, 5'd9, 32'h9A);
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    iss_valid = 1'b1; iss_rd = 5'd5;
    next_cycle();
    iss_valid = 1'b0;
    exp_busy[5] = 1'b1;
    check_busy("mid_busy5_set");
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'hA1;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'hB1;
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      push_exp($sformatf("mid_refuse%0d", i), 1'b1, 5'd7, 32'hA1, 1'b0, 1'b0);
      sb_pop_compare();
      next_cycle();
    end
    // Force is now set; reset asynchronously mid-cycle.
    RST = 1'b1;
    exp_busy = '0;
    push_exp("mid_in_reset", 1'b0, 5'd0, '0, 1'b0, 1'b0);
    sb_pop_compare();
    check_busy("mid_busy_cleared");
    next_cycle();
    RST = 1'b0;
    push_exp("mid_after_release", 1'b1, 5'd7, 32'hA1, 1'b0, 1'b0);
    sb_pop_compare();
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    RST = 1'b1;
    exp_busy = '0;
    #2;
    test_reset();
    test_a_only();
    test_starvation();
    test_scoreboard();
    test_x0();
    test_idle_a();
    test_force_drop();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d expectations never compared", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
